irq_arbiter: RTL and testbench

//  Two-source interrupt controller in front of proc's single interrupt input.

---
 rtl/irq_arbiter.sv | 142 ++++++++++++++
 tb/tb_irq_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_arbiter.sv
// Two-source (key / eth) interrupt controller in front of the core's interrupt input.
// Captures events and payloads, arbitrates round-robin and runs the ack / end-of-interrupt handshake.
module irq_arbiter #(
    parameter int DATA_W      = 32,
    parameter bit EDGE_DETECT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_evt,
    input  logic [DATA_W-1:0] key_data,
    input  logic              eth_evt,
    input  logic [DATA_W-1:0] eth_data,
    input  logic [1:0]        irq_mask,
    input  logic              irq_ack,
    input  logic              irq_eoi,
    output logic              interrupt_key,
    output logic              interrupt_eth,
    output logic [DATA_W-1:0] interrupt_source_data,
    output logic              irq_id,
    output logic [1:0]        overrun,
    output logic              busy
);

    // Handshake: interrupt_key/eth is a level request that stays high, with payload and
    // irq_id stable, until irq_ack is sampled in REQ; irq_eoi is honoured only in SERVICE.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_n;

    logic [1:0]        evt_raw;
    logic [1:0]        evt_prev;
    logic [1:0]        evt;
    logic [DATA_W-1:0] evt_data [2];
    logic [DATA_W-1:0] hold     [2];
    logic [1:0]        pending;
    logic [1:0]        eligible;
    logic              last_grant;
    logic              grant_en;
    logic              grant_id;
    logic [1:0]        grant_oh;

    assign evt_raw     = {eth_evt, key_evt};
    assign evt_data[0] = key_data;
    assign evt_data[1] = eth_data;

    always_comb begin
        evt = evt_raw;
        if (EDGE_DETECT) begin
            evt = evt_raw & ~evt_prev;
        end
    end

    // On a tie the source that did not win last time is granted.
    always_comb begin
        eligible = pending & ~irq_mask;
        grant_id = 1'b0;
        case (eligible)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        grant_en = 1'b0;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    grant_en = 1'b1;
                    state_n  = REQ;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_n = SERVICE;
                end
            end
            SERVICE: begin
                if (irq_eoi) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign grant_oh = {grant_en & grant_id, grant_en & ~grant_id};
    assign busy     = (state != IDLE);

    // A new event on the source being granted re-arms pending (set wins over clear)
    // and is not an overrun, because the grant consumes the older payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_prev              <= 2'b00;
            pending               <= 2'b00;
            overrun               <= 2'b00;
            hold[0]               <= '0;
            hold[1]               <= '0;
            last_grant            <= 1'b0;
            interrupt_key         <= 1'b0;
            interrupt_eth         <= 1'b0;
            interrupt_source_data <= '0;
            irq_id                <= 1'b0;
        end else begin
            evt_prev <= evt_raw;
            for (int s = 0; s < 2; s++) begin
                if (evt[s]) begin
                    hold[s] <= evt_data[s];
                end
            end
            pending <= (pending & ~grant_oh) | evt;
            overrun <= (overrun | (evt & pending)) & ~grant_oh;

            if (grant_en) begin
                interrupt_source_data <= hold[grant_id];
                irq_id                <= grant_id;
                last_grant            <= grant_id;
                interrupt_key         <= ~grant_id;
                interrupt_eth         <= grant_id;
            end else if (state == REQ && irq_ack) begin
                interrupt_key <= 1'b0;
                interrupt_eth <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: expected grants are queued as events are driven
// and compared when the core-facing interrupt rises.
module tb_irq_arbiter;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              key_evt;
    logic [DATA_W-1:0] key_data;
    logic              eth_evt;
    logic [DATA_W-1:0] eth_data;
    logic [1:0]        irq_mask;
    logic              irq_ack;
    logic              irq_eoi;
    logic              interrupt_key;
    logic              interrupt_eth;
    logic [DATA_W-1:0] interrupt_source_data;
    logic              irq_id;
    logic [1:0]        overrun;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;
    logic [DATA_W:0] exp_q[$];   // {irq_id, payload}

    irq_arbiter #(.DATA_W(DATA_W), .EDGE_DETECT(1'b1)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .key_evt               (key_evt),
        .key_data              (key_data),
        .eth_evt               (eth_evt),
        .eth_data              (eth_data),
        .irq_mask              (irq_mask),
        .irq_ack               (irq_ack),
        .irq_eoi               (irq_eoi),
        .interrupt_key         (interrupt_key),
        .interrupt_eth         (interrupt_eth),
        .interrupt_source_data (interrupt_source_data),
        .irq_id                (irq_id),
        .overrun               (overrun),
        .busy                  (busy)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic pulse(input logic k, input logic [DATA_W-1:0] kd,
                         input logic e, input logic [DATA_W-1:0] ed);
        key_evt = k;
        eth_evt = e;
        if (k) key_data = kd;
        if (e) eth_data = ed;
        tick;
        key_evt = 1'b0;
        eth_evt = 1'b0;
    endtask

    task automatic do_ack;
        irq_ack = 1'b1;
        tick;
        irq_ack = 1'b0;
    endtask

    task automatic do_eoi;
        irq_eoi = 1'b1;
        tick;
        irq_eoi = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check_eq(tag, {interrupt_key, interrupt_eth, irq_id, overrun, busy, interrupt_source_data}, 64'd0);
    endtask

    // scoreboard: wait (bounded) for a request, then pop and compare the expected grant
    task automatic wait_irq(input int budget, output int lat);
        logic [DATA_W:0] e;
        lat = 0;
        while (!(interrupt_key || interrupt_eth) && lat < budget) begin
            tick;
            lat++;
        end
        if (!(interrupt_key || interrupt_eth)) begin
            check_eq("irq_timeout", {63'd0, interrupt_key | interrupt_eth}, 64'd1);
            if (exp_q.size() > 0) e = exp_q.pop_front();
        end else if (exp_q.size() == 0) begin
            check_eq("irq_unexpected", {63'd0, interrupt_key | interrupt_eth}, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq("irq_grant",
                     {interrupt_eth, interrupt_key, irq_id, interrupt_source_data},
                     {e[DATA_W], ~e[DATA_W], e[DATA_W], e[DATA_W-1:0]});
        end
    endtask

    task automatic quiet(input int cycles, input string tag);
        int hits;
        hits = 0;
        repeat (cycles) begin
            tick;
            if (interrupt_key || interrupt_eth) hits++;
        end
        check_eq(tag, hits, 0);
    endtask

    initial begin
        int lat;
        int sel;
        logic [DATA_W-1:0] kd;
        logic [DATA_W-1:0] ed;
        logic [1:0]        m_pend;
        logic [DATA_W-1:0] m_hold0;
        logic [DATA_W-1:0] m_hold1;
        logic              m_last;
        logic              g;

        rst      = 1'b1;
        key_evt  = 1'b0;
        eth_evt  = 1'b0;
        key_data = '0;
        eth_data = '0;
        irq_mask = 2'b00;
        irq_ack  = 1'b0;
        irq_eoi  = 1'b0;
        repeat (2) tick;
        rst = 1'b0;
        check_cleared("reset");

        // 1: single key event, latency and handshake
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        pulse(1'b1, 32'hDEADBEEF, 1'b0, '0);
        check_eq("t1_not_yet", interrupt_key, 1'b0);
        wait_irq(4, lat);
        check_eq("t1_latency", lat, 1);
        do_ack;
        check_eq("t1_ack_lines", {interrupt_key, interrupt_eth, busy}, 3'b001);
        check_eq("t1_data_held", interrupt_source_data, 32'hDEADBEEF);
        do_eoi;
        check_eq("t1_eoi_idle", busy, 1'b0);
        do_ack;
        check_eq("t1_ack_in_idle", {busy, interrupt_key}, 2'b00);

        // 2: tie after reset goes to eth, then key
        do_reset;
        check_cleared("t2_reset");
        exp_q.push_back({1'b1, 32'h22});
        exp_q.push_back({1'b0, 32'h11});
        pulse(1'b1, 32'h11, 1'b1, 32'h22);
        wait_irq(4, lat);
        do_eoi;
        check_eq("t2_eoi_in_req", interrupt_eth, 1'b1);
        irq_ack = 1'b1;
        irq_eoi = 1'b1;
        tick;
        irq_ack = 1'b0;
        irq_eoi = 1'b0;
        check_eq("t2_ack_with_eoi", {busy, interrupt_eth}, 2'b10);
        do_eoi;
        wait_irq(4, lat);
        check_eq("t2_second_lat", lat, 1);
        irq_mask = 2'b11;
        tick;
        check_eq("t2_mask_in_req", interrupt_key, 1'b1);
        irq_mask = 2'b00;
        do_ack;
        do_eoi;

        // 3: overwrite while pending -> newest payload, overrun set then cleared on grant
        irq_mask = 2'b01;
        pulse(1'b1, 32'hA, 1'b0, '0);
        tick;
        pulse(1'b1, 32'hB, 1'b0, '0);
        check_eq("t3_overrun_set", overrun, 2'b01);
        check_eq("t3_masked", interrupt_key, 1'b0);
        exp_q.push_back({1'b0, 32'hB});
        irq_mask = 2'b00;
        wait_irq(3, lat);
        check_eq("t3_overrun_clr", overrun, 2'b00);
        do_ack;
        do_eoi;

        // 3b: event on the granted source in the grant cycle
        irq_mask = 2'b01;
        pulse(1'b1, 32'h1, 1'b0, '0);
        tick;
        exp_q.push_back({1'b0, 32'h1});
        exp_q.push_back({1'b0, 32'h2});
        irq_mask = 2'b00;
        pulse(1'b1, 32'h2, 1'b0, '0);
        wait_irq(2, lat);
        check_eq("t3b_no_overrun", overrun, 2'b00);
        do_ack;
        do_eoi;
        wait_irq(3, lat);
        do_ack;
        do_eoi;

        // 4: masked eth stays quiet, then follows one cycle after unmask
        irq_mask = 2'b10;
        exp_q.push_back({1'b1, 32'h55});
        pulse(1'b0, '0, 1'b1, 32'h55);
        quiet(20, "t4_masked_quiet");
        irq_mask = 2'b00;
        wait_irq(2, lat);
        check_eq("t4_unmask_lat", lat, 1);
        do_ack;
        do_eoi;

        // 5: reset while in SERVICE with key pending
        exp_q.push_back({1'b0, 32'h77});
        pulse(1'b1, 32'h77, 1'b0, '0);
        wait_irq(3, lat);
        do_ack;
        pulse(1'b1, 32'h78, 1'b0, '0);
        check_eq("t5_service_busy", busy, 1'b1);
        do_reset;
        check_cleared("t5_reset_mid");
        quiet(20, "t5_no_irq_after_rst");

        // 6: key pulses during eth service, then randomized round-robin
        exp_q.push_back({1'b1, 32'h60});
        pulse(1'b0, '0, 1'b1, 32'h60);
        wait_irq(3, lat);
        do_ack;
        pulse(1'b1, 32'h70, 1'b0, '0);
        tick;
        pulse(1'b1, 32'h71, 1'b0, '0);
        check_eq("t6_overrun", overrun, 2'b01);
        exp_q.push_back({1'b0, 32'h71});
        do_eoi;
        wait_irq(3, lat);
        check_eq("t6_eoi_to_grant", lat, 1);
        do_ack;

        m_pend  = 2'b00;
        m_hold0 = '0;
        m_hold1 = '0;
        m_last  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sel = $urandom_range(1, 3);
            kd  = $urandom;
            ed  = $urandom;
            pulse(sel[0], kd, sel[1], ed);
            if (sel[0]) begin
                m_pend[0] = 1'b1;
                m_hold0   = kd;
            end
            if (sel[1]) begin
                m_pend[1] = 1'b1;
                m_hold1   = ed;
            end
            g = (m_pend == 2'b11) ? ~m_last : m_pend[1];
            exp_q.push_back({g, g ? m_hold1 : m_hold0});
            m_pend[g] = 1'b0;
            m_last    = g;
            do_eoi;
            wait_irq(3, lat);
            do_ack;
        end
        do_eoi;
        if (m_pend != 2'b00) begin
            g = m_pend[1];
            exp_q.push_back({g, g ? m_hold1 : m_hold0});
            wait_irq(3, lat);
            do_ack;
            do_eoi;
        end
        check_eq("t6_final_idle", busy, 1'b0);
        check_eq("q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
